control_multiciclo: RTL and testbench
=====================================

# control_multiciclo

Multi-cycle control FSM for the 32-bit MIPS core. It replaces single-cycle opcode decode with a sequencer that breaks every instruction into fetch, decode, execute, memory and write-back steps. It drives the shared-memory, IR, PC, ALU-mux and register-file enables each cycle. The memory handshake is `mem_ready`, and a memory stall that exceeds a limit parks the core in a fault state.

## Interface
- `WAIT_LIMIT`, 15: maximum consecutive cycles with `mem_ready`=0 in any memory state before fault; range 1–255.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: IR[31:26]; valid from the DECODE cycle onward.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA` out 1: datapath enables and mux selects.
- `ALUSrcB` out 2: 00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `PCSource` out 2: 00 ALU result, 01 ALUOut register.
- `ALUOP` out 3: 000 add, 001 sub, 010 funct, 011 and, 100 slt, 101 or.
- `instr_done` out 1: one-cycle pulse in an instruction's final state.
- `illegal_op` out 1: one-cycle pulse when DECODE sees an unsupported opcode.
- `mem_fault` out 1: sticky; cleared only by `rst`.

## Operation
- Outputs are a Moore decode of the state register. Every output not listed for a state is 0.
- Supported opcodes: R 000000, LW 100011, LWC1 110001 (handled as LW), SW 101011, BEQ 000100, ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101.
- States and outputs:
  - IDLE: all outputs 0.
  - FETCH: MemRead, ALUSrcB=01, ALUOP=000. IRWrite and PCWrite are asserted only while `mem_ready`=1.
  - DECODE: ALUSrcB=11, ALUOP=000. Latches `opcode` into `op_q`.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOP=000.
  - MEM_READ: MemRead, IorD.
  - MEM_WB: MemtoReg, RegWrite, instr_done.
  - MEM_WRITE: MemWrite, IorD. instr_done is asserted on the cycle `mem_ready`=1.
  - R_EXEC: ALUSrcA=1, ALUOP=010.
  - R_WB: RegDst, RegWrite, instr_done.
  - BRANCH: ALUSrcA=1, ALUOP=001, PCWriteCond, PCSource=01, instr_done.
  - I_EXEC: ALUSrcA=1, ALUSrcB=10. ALUOP from `op_q`: ADDI 000, SLTI 100, ANDI 011, ORI 101.
  - I_WB: RegWrite, instr_done.
  - HALT: all outputs 0 except `mem_fault`.
- Transitions:
  - IDLE → FETCH.
  - FETCH → DECODE on `mem_ready`.
  - DECODE → MEM_ADDR (LW/LWC1/SW), R_EXEC, BRANCH or I_EXEC.
  - DECODE → FETCH with `illegal_op` for an unknown opcode. The PC has already advanced by 4, so the instruction is skipped.
  - MEM_ADDR → MEM_READ (loads) or MEM_WRITE (SW).
  - MEM_READ → MEM_WB on `mem_ready`.
  - MEM_WRITE → FETCH on `mem_ready`.
  - R_EXEC → R_WB; I_EXEC → I_WB.
  - R_WB, I_WB, MEM_WB and BRANCH → FETCH.
- Stall counter (8 bit):
  - Increments each cycle in FETCH, MEM_READ or MEM_WRITE while `mem_ready`=0.
  - Clears on `mem_ready`=1 or on leaving those states.
  - When the counter equals `WAIT_LIMIT` with `mem_ready` still 0, the next state is HALT and `mem_fault` sets.
  - `mem_ready`=1 on the limit cycle wins: the access completes and no fault is raised.
- HALT is absorbing until `rst`.

## Timing
- Reset: on a clock edge with `rst`=1, state becomes IDLE and `op_q`, the stall counter and `mem_fault` clear. All outputs are 0 the cycle after. `rst` mid-instruction aborts with no further write enables.
- Cycles per instruction with `mem_ready` tied 1: BEQ 3; R, ADDI/SLTI/ANDI/ORI and SW 4; LW/LWC1 5. The first FETCH after reset follows one IDLE cycle.
- Each stall cycle in a memory state adds exactly one cycle. The output enables are held constant across stall cycles.
- `instr_done` is asserted for exactly one cycle per retired instruction. It is never asserted for an illegal opcode.
- `opcode` is sampled only in DECODE; changes at any other time are ignored.

## Structure
- Shared package `mips_pkg`: opcode constants, ALUOP encodings, ALUSrcB/PCSource encodings, state enum (4-bit). The existing single-cycle decoder also uses these constants.
- One natural sub-module, `clase_opcode`: combinational map from opcode to {MEM_LOAD, MEM_STORE, RTYPE, BRANCH, ITYPE, ILLEGAL} plus the I-type ALUOP. DECODE and I_EXEC use it.

## Test plan
- `rst`=1 for 2 cycles, then 0 with `mem_ready`=1 and opcode 000000 → IDLE, FETCH, DECODE, R_EXEC, R_WB. R_WB shows RegDst=1, RegWrite=1 and instr_done=1; 4 cycles from FETCH to R_WB.
- LW 100011, then LWC1 110001 → each takes 5 cycles. MEM_READ has IorD=1 and MemRead=1; MEM_WB has MemtoReg=1 and RegWrite=1.
- BEQ 000100 → 3 cycles. BRANCH has ALUOP=001, PCWriteCond=1 and PCSource=01.
- SLTI 001010, ANDI 001100, ORI 001101, ADDI 001000 → I_EXEC ALUOP is 100, 011, 101, 000 respectively, with ALUSrcB=10.
- Opcode 111111 → `illegal_op` pulses in DECODE, the next state is FETCH, and there are no RegWrite/MemWrite pulses.
- SW with `mem_ready` held 0 and `WAIT_LIMIT`=3 → HALT entered after the stall limit; `mem_fault`=1 and stays 1 until `rst`. A repeat run with `mem_ready` rising on the limit cycle → SW completes with no fault.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core: opcodes, ALU/mux encodings, the multi-cycle
// sequencer state encoding and the opcode class used by the decoders.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LWC1  = 6'b110001;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_SLT   = 3'b100;
    localparam logic [2:0] ALUOP_OR    = 3'b101;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11,
        S_HALT      = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        CLS_MEM_LOAD  = 3'd0,
        CLS_MEM_STORE = 3'd1,
        CLS_RTYPE     = 3'd2,
        CLS_BRANCH    = 3'd3,
        CLS_ITYPE     = 3'd4,
        CLS_ILLEGAL   = 3'd5
    } opClass_t;

endpackage

// File: rtl/clase_opcode.sv
// Combinational opcode classifier: instruction class plus the ALU operation
// an I-type instruction needs in its execute step.
module clase_opcode
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    output opClass_t   opClass,
    output logic [2:0] iAluOp
);

    // Opcode to class / I-type ALU operation lookup
    always_comb begin
        opClass = CLS_ILLEGAL;
        iAluOp  = ALUOP_ADD;
        case (opcode)
            OP_RTYPE:        opClass = CLS_RTYPE;
            OP_LW, OP_LWC1:  opClass = CLS_MEM_LOAD;
            OP_SW:           opClass = CLS_MEM_STORE;
            OP_BEQ:          opClass = CLS_BRANCH;
            OP_ADDI: begin
                opClass = CLS_ITYPE;
                iAluOp  = ALUOP_ADD;
            end
            OP_SLTI: begin
                opClass = CLS_ITYPE;
                iAluOp  = ALUOP_SLT;
            end
            OP_ANDI: begin
                opClass = CLS_ITYPE;
                iAluOp  = ALUOP_AND;
            end
            OP_ORI: begin
                opClass = CLS_ITYPE;
                iAluOp  = ALUOP_OR;
            end
            default: opClass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_multiciclo.sv
// Multi-cycle MIPS control sequencer: steps each instruction through fetch,
// decode, execute, memory and write-back, with a memory-stall watchdog.
module control_multiciclo
    import mips_pkg::*;
#(
    parameter logic [7:0] WAIT_LIMIT = 8'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOP,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_fault
);

    state_t     state_r;
    state_t     nextState_s;
    logic [5:0] opQ_r;
    logic [7:0] stallCnt_r;
    logic [7:0] stallCntNext_s;
    logic       fault_r;
    logic       memState_s;
    logic       stallLimit_s;
    logic [5:0] opSel_s;
    opClass_t   opClass_s;
    logic [2:0] iAluOp_s;

    // Live opcode is only meaningful in DECODE; later steps use the latched copy
    assign opSel_s = (state_r == S_DECODE) ? opcode : opQ_r;

    clase_opcode uClase (
        .opcode  (opSel_s),
        .opClass (opClass_s),
        .iAluOp  (iAluOp_s)
    );

    assign memState_s   = (state_r == S_FETCH) || (state_r == S_MEM_READ) ||
                          (state_r == S_MEM_WRITE);
    assign stallLimit_s = memState_s && !mem_ready && (stallCnt_r == WAIT_LIMIT);
    assign mem_fault    = fault_r;

    // Next-state and stall-counter computation
    always_comb begin
        nextState_s    = state_r;
        stallCntNext_s = 8'd0;
        if (memState_s && !mem_ready && !stallLimit_s) begin
            stallCntNext_s = stallCnt_r + 8'd1;
        end else begin
            stallCntNext_s = 8'd0;
        end
        case (state_r)
            S_IDLE:   nextState_s = S_FETCH;
            S_FETCH:  nextState_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opClass_s)
                    CLS_MEM_LOAD, CLS_MEM_STORE: nextState_s = S_MEM_ADDR;
                    CLS_RTYPE:                   nextState_s = S_R_EXEC;
                    CLS_BRANCH:                  nextState_s = S_BRANCH;
                    CLS_ITYPE:                   nextState_s = S_I_EXEC;
                    default:                     nextState_s = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  nextState_s = (opClass_s == CLS_MEM_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  nextState_s = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: nextState_s = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    nextState_s = S_R_WB;
            S_I_EXEC:    nextState_s = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH: nextState_s = S_FETCH;
            S_HALT:      nextState_s = S_HALT;
            default:     nextState_s = S_IDLE;
        endcase
        if (stallLimit_s) begin
            nextState_s = S_HALT;
        end else begin
            nextState_s = nextState_s;
        end
    end

    // State, latched opcode, stall counter and sticky fault registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            opQ_r      <= 6'd0;
            stallCnt_r <= 8'd0;
            fault_r    <= 1'b0;
        end else begin
            state_r    <= nextState_s;
            stallCnt_r <= stallCntNext_s;
            if (state_r == S_DECODE) begin
                opQ_r <= opcode;
            end
            if (stallLimit_s) begin
                fault_r <= 1'b1;
            end
        end
    end

    // Moore output decode; FETCH and MEM_WRITE qualify their completion strobes with mem_ready
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        PCSource    = PCSRC_ALU;
        ALUOP       = ALUOP_ADD;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state_r)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMM_SH2;
                illegal_op = (opClass_s == CLS_ILLEGAL);
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOP   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOP       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOP   = iAluOp_s;
            end
            S_I_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: begin
                PCWrite = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: per-cycle comparison of the full output
// vector against hand-built expectations for each instruction class and stall case.
module tb_control_multiciclo;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOP;
    logic       instr_done, illegal_op, mem_fault;

    int checks = 0;
    int failures = 0;

    logic [19:0] outs;
    assign outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                   RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOP,
                   instr_done, illegal_op, mem_fault};

    control_multiciclo #(.WAIT_LIMIT(8'd3)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .ALUOP(ALUOP), .instr_done(instr_done), .illegal_op(illegal_op),
        .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    // Expected output vector in the same field order as outs
    function automatic logic [19:0] mk(
        input logic pcw, input logic pcwc, input logic iord, input logic mr,
        input logic mw, input logic irw, input logic m2r, input logic rd,
        input logic rw, input logic asa, input logic [1:0] asb,
        input logic [1:0] pcs, input logic [2:0] aop,
        input logic done, input logic ill, input logic flt);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aop, done, ill, flt};
    endfunction

    task automatic check_eq(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed %05h expected %05h", tag, obs, exp);
        end
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge
    task automatic cycle(input string tag, input logic [19:0] exp);
        @(negedge clk);
        check_eq(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    logic [19:0] eIdle, eFetch, eFetchStall, eDec, eDecIll, eMemAddr, eMemRead, eMemWb;
    logic [19:0] eMemWrDone, eMemWrStall, eRExec, eRWb, eBranch, eIWb, eHalt;

    task automatic fetch_dec(input string t);
        cycle({t, "_fetch"}, eFetch);
        cycle({t, "_decode"}, eDec);
    endtask

    logic [5:0] iOps [4];
    logic [2:0] iAops[4];

    initial begin
        eIdle       = 20'd0;
        eFetch      = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b000,1'b0,1'b0,1'b0);
        eFetchStall = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,3'b000,1'b0,1'b0,1'b0);
        eDec        = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b000,1'b0,1'b0,1'b0);
        eDecIll     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,3'b000,1'b0,1'b1,1'b0);
        eMemAddr    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,3'b000,1'b0,1'b0,1'b0);
        eMemRead    = mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0,1'b0,1'b0);
        eMemWb      = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000,1'b1,1'b0,1'b0);
        eMemWrDone  = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b1,1'b0,1'b0);
        eMemWrStall = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0,1'b0,1'b0);
        eRExec      = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,3'b010,1'b0,1'b0,1'b0);
        eRWb        = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,3'b000,1'b1,1'b0,1'b0);
        eBranch     = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,3'b001,1'b1,1'b0,1'b0);
        eIWb        = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,3'b000,1'b1,1'b0,1'b0);
        eHalt       = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,3'b000,1'b0,1'b0,1'b1);
        iOps[0] = 6'b001010; iAops[0] = 3'b100;
        iOps[1] = 6'b001100; iAops[1] = 3'b011;
        iOps[2] = 6'b001101; iAops[2] = 3'b101;
        iOps[3] = 6'b001000; iAops[3] = 3'b000;

        rst = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // R-type: IDLE, FETCH, DECODE, R_EXEC, R_WB
        cycle("reset_idle", eIdle);
        fetch_dec("r");
        cycle("r_exec", eRExec);
        cycle("r_wb", eRWb);

        // LW then LWC1
        opcode = 6'b100011;
        fetch_dec("lw");
        cycle("lw_addr", eMemAddr);
        cycle("lw_read", eMemRead);
        cycle("lw_wb", eMemWb);
        opcode = 6'b110001;
        fetch_dec("lwc1");
        cycle("lwc1_addr", eMemAddr);
        cycle("lwc1_read", eMemRead);
        cycle("lwc1_wb", eMemWb);

        // BEQ
        opcode = 6'b000100;
        fetch_dec("beq");
        cycle("beq_branch", eBranch);

        // I-types; opcode scrambled after DECODE must not disturb the latched op
        for (int i = 0; i < 4; i++) begin
            opcode = iOps[i];
            fetch_dec("itype");
            opcode = 6'b111111;
            cycle("itype_exec", mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,
                                   2'b10,2'b00,iAops[i],1'b0,1'b0,1'b0));
            cycle("itype_wb", eIWb);
        end

        // Illegal opcode: skipped, straight back to FETCH
        opcode = 6'b111111;
        cycle("ill_fetch", eFetch);
        cycle("ill_decode", eDecIll);
        opcode = 6'b000100;

        // Next BEQ with two FETCH stall cycles (also shows return to FETCH)
        mem_ready = 1'b0;
        cycle("fetch_stall0", eFetchStall);
        cycle("fetch_stall1", eFetchStall);
        mem_ready = 1'b1;
        fetch_dec("beq2");
        cycle("beq2_branch", eBranch);

        // SW with memory never ready: 4 stall cycles (count 0..3) then HALT
        opcode = 6'b101011;
        fetch_dec("sw");
        cycle("sw_addr", eMemAddr);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cycle("sw_stall", eMemWrStall);
        cycle("halt0", eHalt);
        mem_ready = 1'b1;
        opcode = 6'b000000;
        cycle("halt1", eHalt);
        cycle("halt2", eHalt);

        rst = 1'b1;
        cycle("halt_before_rst", eHalt);
        rst = 1'b0;
        cycle("rst_clears_fault", eIdle);

        // SW with mem_ready arriving exactly on the limit cycle: no fault
        opcode = 6'b101011;
        fetch_dec("sw2");
        cycle("sw2_addr", eMemAddr);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle("sw2_stall", eMemWrStall);
        mem_ready = 1'b1;
        cycle("sw2_limit_done", eMemWrDone);
        cycle("sw2_next_fetch", eFetch);

        // Reset in the middle of a load aborts to IDLE with no write enables
        opcode = 6'b100011;
        cycle("abort_decode", eDec);
        cycle("abort_addr", eMemAddr);
        rst = 1'b1;
        cycle("abort_read", eMemRead);
        rst = 1'b0;
        cycle("abort_idle", eIdle);
        cycle("abort_refetch", eFetch);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
